// File: rtl/serial_subtractor5_if.sv
// ============================================================================
// Module   : serial_subtractor5_if
// Purpose  : start/busy/done handshake and operand/result bus of the
//            bit-serial subtractor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_subtractor5_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor5.sv
// ============================================================================
// Module   : serial_subtractor5
// Purpose  : bit-serial ripple-borrow subtractor, diff = a - b - bin, LSB first.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor5 #(
  parameter int WIDTH = 5
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_subtractor5_if.slave bus
);

  localparam int                  c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic               r_br;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_res;
  logic               r_amsb;
  logic               r_bmsb;
  logic [WIDTH-1:0]   r_diff;
  logic               r_borrow;
  logic               r_ovf;

  logic               w_x;
  logic               w_y;
  logic               w_d;
  logic               w_bout;
  logic [WIDTH-1:0]   w_res_next;

  // Single full-subtractor cell fed by the operand LSBs and the borrow FF
  assign w_x        = r_sa[0];
  assign w_y        = r_sb[0];
  assign w_d        = w_x ^ w_y ^ r_br;
  assign w_bout     = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_amsb   <= 1'b0;
      r_bmsb   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= bus.bin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_amsb  <= bus.a[WIDTH-1];
            r_bmsb  <= bus.b[WIDTH-1];
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_next;
          r_br  <= w_bout;
          // Last bit: w_d is the result MSB, so overflow is decided here
          if (r_cnt == c_LAST) begin
            r_diff   <= w_res_next;
            r_borrow <= w_bout;
            r_ovf    <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            r_state  <= c_DONE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state != c_IDLE);
  assign bus.done   = (r_state == c_DONE);
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;
  assign bus.ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor5.sv
// ============================================================================
// Module   : tb_serial_subtractor5
// Purpose  : directed and exhaustive-shuffled check of serial_subtractor5.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor5;

  localparam int W = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   prev_diff;
  int   prev_borrow;

  serial_subtractor5_if #(.WIDTH(W)) bus ();

  serial_subtractor5 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  function automatic void model(input int a, input int b, input int bi,
                                output int d, output int bo, output int ov);
    int full;
    int sa;
    int sb;
    int s;
    full = a - b - bi;
    d    = ((full % (1 << W)) + (1 << W)) % (1 << W);
    bo   = (full < 0) ? 1 : 0;
    sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    s    = sa - sb - bi;
    ov   = (s < -(1 << (W - 1)) || s > (1 << (W - 1)) - 1) ? 1 : 0;
  endfunction

  task automatic run_op(input int a, input int b, input int bi,
                        input bit meddle, input bit full_chk, input string tag);
    int ed;
    int eb;
    int eo;
    int lat;
    int busy_cnt;
    bit seen;
    model(a, b, bi, ed, eb, eo);
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.bin   = bi[0];
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      if (bus.busy) busy_cnt++;
      if (i == 0) begin
        chk({tag, "_hold_diff"}, int'(bus.diff), prev_diff);
        chk({tag, "_hold_borrow"}, int'(bus.borrow), prev_borrow);
      end
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (meddle && i >= 1) begin
        bus.start = 1'b1;
        bus.a     = ~bus.a;
        bus.b     = W'($urandom);
      end
      step();
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_diff"}, int'(bus.diff), ed);
    chk({tag, "_borrow"}, int'(bus.borrow), eb);
    chk({tag, "_ovf"}, int'(bus.ovf), eo);
    step();
    if (full_chk) begin
      chk({tag, "_busy_cycles"}, busy_cnt, W + 1);
      chk({tag, "_idle_busy"}, int'(bus.busy), 0);
      chk({tag, "_done_pulse"}, int'(bus.done), 0);
    end
    prev_diff   = ed;
    prev_borrow = eb;
  endtask

  initial begin
    int order[2048];
    bit saw_done;
    n_checks    = 0;
    n_errors    = 0;
    prev_diff   = 0;
    prev_borrow = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    step();
    step();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_diff", int'(bus.diff), 0);
    chk("rst_borrow", int'(bus.borrow), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    rst = 1'b0;
    step();

    run_op(13, 6, 0, 1'b0, 1'b1, "t1");
    run_op(6, 13, 0, 1'b0, 1'b1, "t2");
    run_op(0, 0, 1, 1'b0, 1'b1, "t3");
    run_op(16, 1, 0, 1'b0, 1'b1, "t4a");
    run_op(15, 31, 0, 1'b0, 1'b1, "t4b");
    run_op(13, 6, 0, 1'b1, 1'b1, "t5");
    run_op(31, 0, 1, 1'b0, 1'b1, "t5_next");

    // Abort mid-operation
    bus.a     = W'(9);
    bus.b     = W'(3);
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_done", int'(bus.done), 0);
    chk("t6_diff", int'(bus.diff), 0);
    chk("t6_borrow", int'(bus.borrow), 0);
    chk("t6_ovf", int'(bus.ovf), 0);
    saw_done = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      step();
      if (bus.done) saw_done = 1'b1;
    end
    chk("t6_no_done", int'(saw_done), 0);
    prev_diff   = 0;
    prev_borrow = 0;

    // Every (a,b,bin) combination in shuffled order
    for (int i = 0; i < 2048; i++) order[i] = i;
    for (int i = 2047; i > 0; i--) begin
      int j;
      int t;
      j        = int'($urandom_range(i, 0));
      t        = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 2048; i++) begin
      run_op((order[i] >> 6) & 31, (order[i] >> 1) & 31, order[i] & 1,
             1'($urandom), 1'b0, "sweep");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
